cpu_controller: RTL and testbench
=================================

// Module: cpu_controller
// PURPOSE
//  Eight-phase instruction sequencer for the 8-bit CPU. Steps the fetch/decode/execute cycle,
//  drives strobes for PC, IR, accumulator, memory and ALU opcode, resolves SKZ from the ALU zero
//  flag, stalls on memory wait and latches HLT until resume. Sits between the IR and the datapath.
// PARAMETERS
//  RET_W    16  width of the retired-instruction counter (wraps modulo 2**RET_W)
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst        in   1      reset, synchronous, active-high
//  opcode     in   3      IR[7:5]; valid from phase IDLE onward
//  zero       in   1      ALU SKZ_cmp (accumulator == 0)
//  mem_ready  in   1      memory read data valid; stalls INST_FETCH / OP_FETCH when 0
//  resume     in   1      one-cycle pulse; releases halt
//  alu_op     out  3      opcode forwarded to ALU (=opcode)
//  sel        out  1      1: address mux selects PC, 0: IR operand
//  rd         out  1      memory read enable
//  ld_ir      out  1      load IR
//  inc_pc     out  1      PC += 1
//  ld_pc      out  1      PC <= operand (JMP)
//  ld_ac      out  1      accumulator <= ALU result
//  wr         out  1      memory write
//  data_e     out  1      accumulator drives data bus
//  halted     out  1      CPU halted
//  phase      out  3      current phase (debug)
//  retired    out  RET_W  instructions completed
// BEHAVIOUR
//  Phases 0..7: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE; wrap 7->0.
//  Advance one phase per clock, except: hold in INST_FETCH/OP_FETCH while mem_ready=0; hold in
//   INST_ADDR while halted.
//  ALUOP = opcode in {ADD 010, AND 011, XOR 100, LDA 101}. Strobes are Moore decode of phase+opcode:
//   INST_ADDR: sel. INST_FETCH: sel,rd. INST_LOAD/IDLE: sel,rd,ld_ir.
//   OP_ADDR: inc_pc; HLT(000) sets halted at end of cycle.
//   OP_FETCH: rd=ALUOP. ALU_OP: rd=ALUOP; inc_pc=SKZ(001)&zero; ld_pc=JMP(111); data_e=STO(110).
//   STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=JMP; wr=STO; data_e=STO.
//  zero is sampled in ALU_OP only (combinational use, same cycle).
//  All strobes are 0 while halted, except sel=1. inc_pc/wr/ld_* pulse for exactly one cycle per
//   phase visit; a stall never repeats them (stall phases carry only sel/rd).
//  Halt: halted=1 from the cycle after OP_ADDR(HLT); phase then runs to STORE, wraps to INST_ADDR,
//   and holds there. resume=1 while halted clears halted next edge; fetch restarts the edge after.
//   resume while not halted is ignored. HLT with resume in the same OP_ADDR cycle: halt wins.
//  retired += 1 on each STORE->INST_ADDR transition; the HLT instruction counts once.
//  Reset (any phase, mid-stall): phase=INST_ADDR, halted=0, retired=0; outputs then sel=1,
//   all other strobes 0, alu_op=opcode.
// STRUCTURE
//  Shared package cpu_pkg: opcode constants (HLT..JMP), phase encodings, and an is_aluop
//   function reused by the ALU and the decoder.
//  One sub-module: cpu_ctrl_decode (combinational phase/opcode/zero/halted -> strobe table);
//   the top holds the phase register, halt latch, stall logic and retired counter.
// TESTING
//  Reset, ADD, mem_ready=1 -> 8 cycles; ld_ir in phases 2-3, ld_ac only in STORE; retired=1.
//  SKZ, zero=1 -> inc_pc pulses in OP_ADDR and ALU_OP (2 total); zero=0 -> 1 total.
//  JMP -> ld_pc=1 in ALU_OP and STORE; wr=0, rd=0 in OP_FETCH..STORE.
//  STO, mem_ready=0 for 3 cycles in INST_FETCH -> phase holds 3 extra; wr=1 one cycle only.
//  HLT -> halted=1, phase parks at 0, strobes 0 for 20 cycles; resume -> next fetch; retired+1.
//  rst asserted mid-OP_FETCH stall -> phase=0, retired=0, halted=0 next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the 8-bit CPU controller, decoder and ALU.
//   - OPC_*      : 3-bit opcodes carried in IR[7:5]
//   - phase_t    : the eight sequencer phases, in execution order
//   - strobe_t   : bundle of datapath strobes produced by the decoder
//   - is_aluop() : true for the opcodes whose result comes through the ALU
package cpu_pkg;

  localparam logic [2:0] OPC_HLT = 3'b000;
  localparam logic [2:0] OPC_SKZ = 3'b001;
  localparam logic [2:0] OPC_ADD = 3'b010;
  localparam logic [2:0] OPC_AND = 3'b011;
  localparam logic [2:0] OPC_XOR = 3'b100;
  localparam logic [2:0] OPC_LDA = 3'b101;
  localparam logic [2:0] OPC_STO = 3'b110;
  localparam logic [2:0] OPC_JMP = 3'b111;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  typedef struct packed {
    logic sel;
    logic rd;
    logic ld_ir;
    logic inc_pc;
    logic ld_pc;
    logic ld_ac;
    logic wr;
    logic data_e;
  } strobe_t;

  // Opcodes that read an operand from memory and write the accumulator.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == OPC_ADD) || (op == OPC_AND) || (op == OPC_XOR) || (op == OPC_LDA);
  endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// cpu_controller_if: signal bundle between the instruction sequencer and the
// IR/ALU/memory datapath.
//   master modport : the sequencer (reads opcode/zero/mem_ready/resume,
//                    drives strobes, halted, phase, retired)
//   slave modport  : the datapath side (the mirror image)
// RET_W must match the RET_W of the cpu_controller it is connected to.
interface cpu_controller_if #(
  parameter int RET_W = 16
);

  logic [2:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             resume;
  logic [2:0]       alu_op;
  logic             sel;
  logic             rd;
  logic             ld_ir;
  logic             inc_pc;
  logic             ld_pc;
  logic             ld_ac;
  logic             wr;
  logic             data_e;
  logic             halted;
  logic [2:0]       phase;
  logic [RET_W-1:0] retired;

  modport master (
    input  opcode, zero, mem_ready, resume,
    output alu_op, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e,
    output halted, phase, retired
  );

  modport slave (
    output opcode, zero, mem_ready, resume,
    input  alu_op, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e,
    input  halted, phase, retired
  );

endinterface

// File: rtl/cpu_ctrl_decode.sv
// cpu_ctrl_decode: purely combinational strobe table of the sequencer.
//   phase   in  current sequencer phase
//   opcode  in  IR[7:5]
//   zero    in  ALU accumulator-is-zero flag (only looked at in ALU_OP)
//   halted  in  halt latch; forces every strobe low except sel
//   strobes out decoded datapath strobes
// Stall phases (INST_FETCH, OP_FETCH) only ever carry sel/rd, so holding the
// phase never repeats a pulse strobe.
module cpu_ctrl_decode
  import cpu_pkg::*;
(
  input  phase_t     phase,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       halted,
  output strobe_t    strobes
);

  logic aluop;
  logic op_skz;
  logic op_jmp;
  logic op_sto;

  assign aluop  = is_aluop(opcode);
  assign op_skz = (opcode == OPC_SKZ);
  assign op_jmp = (opcode == OPC_JMP);
  assign op_sto = (opcode == OPC_STO);

  always_comb begin
    strobes = '0;
    if (halted) begin
      // Keep the address mux on the PC so the parked fetch address is stable.
      strobes.sel = 1'b1;
    end else begin
      case (phase)
        INST_ADDR: begin
          strobes.sel = 1'b1;
        end
        INST_FETCH: begin
          strobes.sel = 1'b1;
          strobes.rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          strobes.sel   = 1'b1;
          strobes.rd    = 1'b1;
          strobes.ld_ir = 1'b1;
        end
        OP_ADDR: begin
          strobes.inc_pc = 1'b1;
        end
        OP_FETCH: begin
          strobes.rd = aluop;
        end
        ALU_OP: begin
          strobes.rd     = aluop;
          strobes.inc_pc = op_skz & zero;   // skip next instruction
          strobes.ld_pc  = op_jmp;
          strobes.data_e = op_sto;
        end
        STORE: begin
          strobes.rd     = aluop;
          strobes.ld_ac  = aluop;
          strobes.ld_pc  = op_jmp;
          strobes.wr     = op_sto;
          strobes.data_e = op_sto;
        end
      endcase
    end
  end

endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: eight-phase fetch/decode/execute sequencer of the 8-bit CPU.
//   clk  in  single clock, rising edge
//   rst  in  synchronous active-high reset
//   bus  master modport of cpu_controller_if:
//        opcode/zero/mem_ready/resume in; alu_op, sel, rd, ld_ir, inc_pc,
//        ld_pc, ld_ac, wr, data_e, halted, phase, retired out
// Holds the phase register, the halt latch, memory-wait stall logic and the
// retired-instruction counter; strobe decoding lives in cpu_ctrl_decode.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int RET_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  cpu_controller_if.master bus
);

  phase_t           phase_reg, phase_next;
  logic             halted_reg, halted_next;
  logic [RET_W-1:0] retired_reg, retired_next;
  strobe_t          strobes;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg   <= INST_ADDR;
      halted_reg  <= 1'b0;
      retired_reg <= '0;
    end else begin
      phase_reg   <= phase_next;
      halted_reg  <= halted_next;
      retired_reg <= retired_next;
    end
  end

  always_comb begin
    phase_next   = phase_reg;
    halted_next  = halted_reg;
    retired_next = retired_reg;

    unique case (phase_reg)
      // Park here while halted; the edge that clears the latch still holds,
      // so the fetch restarts on the edge after resume.
      INST_ADDR:  if (!halted_reg) phase_next = INST_FETCH;
      INST_FETCH: if (bus.mem_ready) phase_next = INST_LOAD;
      OP_FETCH:   if (bus.mem_ready) phase_next = ALU_OP;
      STORE: begin
        phase_next   = INST_ADDR;
        retired_next = retired_reg + 1'b1;
      end
      default:    phase_next = phase_t'(phase_reg + 3'd1);
    endcase

    // A HLT is only decoded while running, so a resume arriving in the same
    // OP_ADDR cycle is ignored and the halt wins.
    if (halted_reg) begin
      if (bus.resume) halted_next = 1'b0;
    end else if (phase_reg == OP_ADDR && bus.opcode == OPC_HLT) begin
      halted_next = 1'b1;
    end
  end

  cpu_ctrl_decode u_decode (
    .phase   (phase_reg),
    .opcode  (bus.opcode),
    .zero    (bus.zero),
    .halted  (halted_reg),
    .strobes (strobes)
  );

  assign bus.alu_op  = bus.opcode;
  assign bus.sel     = strobes.sel;
  assign bus.rd      = strobes.rd;
  assign bus.ld_ir   = strobes.ld_ir;
  assign bus.inc_pc  = strobes.inc_pc;
  assign bus.ld_pc   = strobes.ld_pc;
  assign bus.ld_ac   = strobes.ld_ac;
  assign bus.wr      = strobes.wr;
  assign bus.data_e  = strobes.data_e;
  assign bus.halted  = halted_reg;
  assign bus.phase   = phase_reg;
  assign bus.retired = retired_reg;

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: directed bench for cpu_controller.
// A table of per-cycle vectors (inputs + expected phase/strobes/halted/retired)
// covers ADD, SKZ (zero=1 and zero=0), JMP and LDA with an operand stall;
// hand-written sequences cover the instruction-fetch stall with STO, HLT
// parking and resume, halt-versus-resume priority and reset during a stall.
// Strobe vectors are {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e}.
module tb_cpu_controller;

  localparam logic [2:0] HLT = 3'b000;
  localparam logic [2:0] SKZ = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] LDA = 3'b101;
  localparam logic [2:0] STO = 3'b110;
  localparam logic [2:0] JMP = 3'b111;

  typedef struct {
    logic [2:0] op;
    logic       z;
    logic       rdy;
    logic       res;
    logic [2:0] ph;
    logic [7:0] stb;
    logic       hlt;
    int         ret;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   wr_seen;
  int   de_seen;
  int   inc_seen;
  vec_t vecs[$];

  cpu_controller_if #(.RET_W(16)) bus ();

  cpu_controller #(.RET_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] stb;
  assign stb = {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc, bus.ld_ac, bus.wr, bus.data_e};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic z, input logic rdy, input logic res);
    bus.opcode    = op;
    bus.zero      = z;
    bus.mem_ready = rdy;
    bus.resume    = res;
  endtask

  // One clock: apply inputs, compare mid-cycle, then advance past the edge.
  task automatic cyc(input string tag, input int idx, input logic [2:0] op, input logic z,
                     input logic rdy, input logic res, input logic [2:0] ph,
                     input logic [7:0] stb_e, input logic hlt, input int ret);
    drive(op, z, rdy, res);
    @(negedge clk);
    chk({tag, ".phase"},   idx, 32'(bus.phase),   32'(ph));
    chk({tag, ".strobes"}, idx, 32'(stb),         32'(stb_e));
    chk({tag, ".halted"},  idx, 32'(bus.halted),  32'(hlt));
    chk({tag, ".retired"}, idx, 32'(bus.retired), ret);
    chk({tag, ".alu_op"},  idx, 32'(bus.alu_op),  32'(op));
    wr_seen  += int'(bus.wr);
    de_seen  += int'(bus.data_e);
    inc_seen += int'(bus.inc_pc);
    $display("%s %0d: op=%0d ph=%0d stb=%b halted=%b retired=%0d",
             tag, idx, op, bus.phase, stb, bus.halted, bus.retired);
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [2:0] op, input logic z, input logic rdy, input logic res,
                     input logic [2:0] ph, input logic [7:0] s, input logic hlt, input int ret);
    vec_t v;
    v.op = op; v.z = z; v.rdy = rdy; v.res = res;
    v.ph = ph; v.stb = s; v.hlt = hlt; v.ret = ret;
    vecs.push_back(v);
  endtask

  initial begin
    logic       sto_rdy[11];
    logic [2:0] sto_ph[11];
    logic [7:0] sto_stb[11];

    checks = 0; errors = 0;
    wr_seen = 0; de_seen = 0; inc_seen = 0;

    // ADD, resume pulse while running is ignored
    add(ADD,0,1,0, 0, 8'b1000_0000, 0, 0);
    add(ADD,0,1,0, 1, 8'b1100_0000, 0, 0);
    add(ADD,0,1,1, 2, 8'b1110_0000, 0, 0);
    add(ADD,0,1,0, 3, 8'b1110_0000, 0, 0);
    add(ADD,0,1,0, 4, 8'b0001_0000, 0, 0);
    add(ADD,0,1,0, 5, 8'b0100_0000, 0, 0);
    add(ADD,0,1,0, 6, 8'b0100_0000, 0, 0);
    add(ADD,0,1,0, 7, 8'b0100_0100, 0, 0);
    // SKZ with zero=1: inc_pc in OP_ADDR and ALU_OP
    add(SKZ,1,1,0, 0, 8'b1000_0000, 0, 1);
    add(SKZ,1,1,0, 1, 8'b1100_0000, 0, 1);
    add(SKZ,1,1,0, 2, 8'b1110_0000, 0, 1);
    add(SKZ,1,1,0, 3, 8'b1110_0000, 0, 1);
    add(SKZ,1,1,0, 4, 8'b0001_0000, 0, 1);
    add(SKZ,1,1,0, 5, 8'b0000_0000, 0, 1);
    add(SKZ,1,1,0, 6, 8'b0001_0000, 0, 1);
    add(SKZ,1,1,0, 7, 8'b0000_0000, 0, 1);
    // SKZ with zero=0 in ALU_OP; zero=1 outside ALU_OP has no effect
    add(SKZ,0,1,0, 0, 8'b1000_0000, 0, 2);
    add(SKZ,0,1,0, 1, 8'b1100_0000, 0, 2);
    add(SKZ,0,1,0, 2, 8'b1110_0000, 0, 2);
    add(SKZ,0,1,0, 3, 8'b1110_0000, 0, 2);
    add(SKZ,0,1,0, 4, 8'b0001_0000, 0, 2);
    add(SKZ,1,1,0, 5, 8'b0000_0000, 0, 2);
    add(SKZ,0,1,0, 6, 8'b0000_0000, 0, 2);
    add(SKZ,1,1,0, 7, 8'b0000_0000, 0, 2);
    // JMP: ld_pc in ALU_OP and STORE, no rd/wr
    add(JMP,0,1,0, 0, 8'b1000_0000, 0, 3);
    add(JMP,0,1,0, 1, 8'b1100_0000, 0, 3);
    add(JMP,0,1,0, 2, 8'b1110_0000, 0, 3);
    add(JMP,0,1,0, 3, 8'b1110_0000, 0, 3);
    add(JMP,0,1,0, 4, 8'b0001_0000, 0, 3);
    add(JMP,0,1,0, 5, 8'b0000_0000, 0, 3);
    add(JMP,0,1,0, 6, 8'b0000_1000, 0, 3);
    add(JMP,0,1,0, 7, 8'b0000_1000, 0, 3);
    // LDA with two OP_FETCH wait cycles
    add(LDA,1,1,0, 0, 8'b1000_0000, 0, 4);
    add(LDA,1,1,0, 1, 8'b1100_0000, 0, 4);
    add(LDA,1,1,0, 2, 8'b1110_0000, 0, 4);
    add(LDA,1,1,0, 3, 8'b1110_0000, 0, 4);
    add(LDA,1,1,0, 4, 8'b0001_0000, 0, 4);
    add(LDA,1,0,0, 5, 8'b0100_0000, 0, 4);
    add(LDA,1,0,0, 5, 8'b0100_0000, 0, 4);
    add(LDA,1,1,0, 5, 8'b0100_0000, 0, 4);
    add(LDA,1,1,0, 6, 8'b0100_0000, 0, 4);
    add(LDA,1,1,0, 7, 8'b0100_0100, 0, 4);

    // Reset state
    rst = 1'b1;
    drive(ADD, 0, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset.phase",   0, 32'(bus.phase),   32'd0);
    chk("reset.strobes", 0, 32'(stb),         32'h80);
    chk("reset.halted",  0, 32'(bus.halted),  32'd0);
    chk("reset.retired", 0, 32'(bus.retired), 32'd0);
    chk("reset.alu_op",  0, 32'(bus.alu_op),  32'(ADD));
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      cyc("vec", i, vecs[i].op, vecs[i].z, vecs[i].rdy, vecs[i].res,
          vecs[i].ph, vecs[i].stb, vecs[i].hlt, vecs[i].ret);

    // STO with three INST_FETCH wait cycles: 11 cycles, wr exactly once
    sto_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    sto_ph  = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    sto_stb = '{8'b1000_0000, 8'b1100_0000, 8'b1100_0000, 8'b1100_0000, 8'b1100_0000,
                8'b1110_0000, 8'b1110_0000, 8'b0001_0000, 8'b0000_0000, 8'b0000_0001,
                8'b0000_0011};
    wr_seen = 0; de_seen = 0; inc_seen = 0;
    for (int i = 0; i < 11; i++)
      cyc("sto", i, STO, 1'b0, sto_rdy[i], 1'b0, sto_ph[i], sto_stb[i], 1'b0, 5);
    chk("sto.wr_count",     0, 32'(wr_seen),  32'd1);
    chk("sto.data_e_count", 0, 32'(de_seen),  32'd2);
    chk("sto.inc_pc_count", 0, 32'(inc_seen), 32'd1);

    // HLT: halted from OP_FETCH on, parks at INST_ADDR, 20 idle cycles
    cyc("hlt", 0, HLT, 0, 1, 0, 3'd0, 8'b1000_0000, 0, 6);
    cyc("hlt", 1, HLT, 0, 1, 0, 3'd1, 8'b1100_0000, 0, 6);
    cyc("hlt", 2, HLT, 0, 1, 0, 3'd2, 8'b1110_0000, 0, 6);
    cyc("hlt", 3, HLT, 0, 1, 0, 3'd3, 8'b1110_0000, 0, 6);
    cyc("hlt", 4, HLT, 0, 1, 0, 3'd4, 8'b0001_0000, 0, 6);
    cyc("hlt", 5, HLT, 0, 1, 0, 3'd5, 8'b1000_0000, 1, 6);
    cyc("hlt", 6, HLT, 1, 1, 0, 3'd6, 8'b1000_0000, 1, 6);
    cyc("hlt", 7, HLT, 0, 1, 0, 3'd7, 8'b1000_0000, 1, 6);
    for (int i = 0; i < 20; i++)
      cyc("park", i, (i % 2 == 0) ? STO : ADD, 1'b1, 1'(i % 3 != 0), 1'b0,
          3'd0, 8'b1000_0000, 1'b1, 7);
    cyc("resume", 0, ADD, 0, 1, 1, 3'd0, 8'b1000_0000, 1, 7);
    cyc("resume", 1, ADD, 0, 1, 0, 3'd0, 8'b1000_0000, 0, 7);
    cyc("resume", 2, ADD, 0, 1, 0, 3'd1, 8'b1100_0000, 0, 7);
    cyc("resume", 3, ADD, 0, 1, 0, 3'd2, 8'b1110_0000, 0, 7);
    cyc("resume", 4, ADD, 0, 1, 0, 3'd3, 8'b1110_0000, 0, 7);
    cyc("resume", 5, ADD, 0, 1, 0, 3'd4, 8'b0001_0000, 0, 7);
    cyc("resume", 6, ADD, 0, 1, 0, 3'd5, 8'b0100_0000, 0, 7);
    cyc("resume", 7, ADD, 0, 1, 0, 3'd6, 8'b0100_0000, 0, 7);
    cyc("resume", 8, ADD, 0, 1, 0, 3'd7, 8'b0100_0100, 0, 7);

    // HLT with resume in the same OP_ADDR cycle: halt wins
    cyc("hltwin", 0, HLT, 0, 1, 0, 3'd0, 8'b1000_0000, 0, 8);
    cyc("hltwin", 1, HLT, 0, 1, 0, 3'd1, 8'b1100_0000, 0, 8);
    cyc("hltwin", 2, HLT, 0, 1, 0, 3'd2, 8'b1110_0000, 0, 8);
    cyc("hltwin", 3, HLT, 0, 1, 0, 3'd3, 8'b1110_0000, 0, 8);
    cyc("hltwin", 4, HLT, 0, 1, 1, 3'd4, 8'b0001_0000, 0, 8);
    cyc("hltwin", 5, HLT, 0, 1, 0, 3'd5, 8'b1000_0000, 1, 8);
    cyc("hltwin", 6, HLT, 0, 1, 0, 3'd6, 8'b1000_0000, 1, 8);
    cyc("hltwin", 7, HLT, 0, 1, 0, 3'd7, 8'b1000_0000, 1, 8);
    cyc("hltwin", 8, HLT, 0, 1, 0, 3'd0, 8'b1000_0000, 1, 9);
    cyc("hltwin", 9, HLT, 0, 1, 1, 3'd0, 8'b1000_0000, 1, 9);
    cyc("hltwin", 10, ADD, 0, 1, 0, 3'd0, 8'b1000_0000, 0, 9);
    cyc("hltwin", 11, ADD, 0, 1, 0, 3'd1, 8'b1100_0000, 0, 9);

    // Reset during an OP_FETCH stall
    cyc("rststall", 0, ADD, 0, 1, 0, 3'd2, 8'b1110_0000, 0, 9);
    cyc("rststall", 1, ADD, 0, 1, 0, 3'd3, 8'b1110_0000, 0, 9);
    cyc("rststall", 2, ADD, 0, 1, 0, 3'd4, 8'b0001_0000, 0, 9);
    cyc("rststall", 3, ADD, 0, 0, 0, 3'd5, 8'b0100_0000, 0, 9);
    rst = 1'b1;
    cyc("rststall", 4, ADD, 0, 0, 0, 3'd5, 8'b0100_0000, 0, 9);
    rst = 1'b0;
    cyc("rststall", 5, ADD, 0, 0, 0, 3'd0, 8'b1000_0000, 0, 0);
    cyc("rststall", 6, ADD, 0, 1, 0, 3'd1, 8'b1100_0000, 0, 0);
    cyc("rststall", 7, ADD, 0, 1, 0, 3'd2, 8'b1110_0000, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
